// File: rtl/bram_capture_writer.sv
// bram_capture_writer
//
// Captures count_max+1 consecutive valid 32-bit stream samples after a start
// pulse and writes them to a BRAM port at byte addresses 0, 4, 8, ...
// Software observes progress through busy/done and the word counter.
//
// Ports:
//   clk         system clock, rising edge
//   resetn      synchronous active-low reset
//   start       one-cycle capture request (ignored while capturing)
//   abort       one-cycle cancel request; wins over start
//   count_max   index of the last word to capture, latched at start
//   s_data      sample data
//   s_valid     sample qualifier, no backpressure
//   busy        capture in progress
//   done        last capture ran to completion (level)
//   word_count  words written in the current/last capture
//   bram_addr   BRAM byte address {count, 2'b00}
//   bram_wdata  BRAM write data
//   bram_en     BRAM port enable
//   bram_we     BRAM byte write enables, all ones or all zeros
module bram_capture_writer #(
  parameter int unsigned COUNT_WIDTH = 13
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   start,
  input  logic                   abort,
  input  logic [COUNT_WIDTH-1:0] count_max,
  input  logic [31:0]            s_data,
  input  logic                   s_valid,
  output logic                   busy,
  output logic                   done,
  output logic [COUNT_WIDTH:0]   word_count,
  output logic [COUNT_WIDTH+1:0] bram_addr,
  output logic [31:0]            bram_wdata,
  output logic                   bram_en,
  output logic [3:0]             bram_we
);

  typedef enum logic [1:0] {
    StIdle,
    StCapture,
    StDone
  } state_e;

  localparam logic [COUNT_WIDTH-1:0] CountOne = COUNT_WIDTH'(1);
  localparam logic [COUNT_WIDTH:0]   WordOne  = (COUNT_WIDTH + 1)'(1);

  state_e                 state_q, state_d;
  logic [COUNT_WIDTH-1:0] count_q, count_d;
  logic [COUNT_WIDTH-1:0] count_max_q, count_max_d;
  logic [COUNT_WIDTH:0]   word_count_q, word_count_d;
  logic [COUNT_WIDTH+1:0] addr_q, addr_d;
  logic [31:0]            wdata_q, wdata_d;
  logic                   en_q, en_d;
  logic [3:0]             we_q, we_d;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q      <= StIdle;
      count_q      <= '0;
      count_max_q  <= '0;
      word_count_q <= '0;
      addr_q       <= '0;
      wdata_q      <= '0;
      en_q         <= 1'b0;
      we_q         <= 4'h0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      count_max_q  <= count_max_d;
      word_count_q <= word_count_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      en_q         <= en_d;
      we_q         <= we_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    count_max_d  = count_max_q;
    word_count_d = word_count_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    // The port strobes only for the cycle after an accepted sample.
    en_d         = 1'b0;
    we_d         = 4'h0;

    case (state_q)
      StIdle, StDone: begin
        if (abort) begin
          state_d = StIdle;
        end else if (start) begin
          state_d      = StCapture;
          count_max_d  = count_max;
          count_d      = '0;
          word_count_d = '0;
        end
      end

      StCapture: begin
        if (abort) begin
          // Partial word_count is kept so software can see how far it got.
          state_d = StIdle;
        end else if (s_valid) begin
          addr_d       = {count_q, 2'b00};
          wdata_d      = s_data;
          en_d         = 1'b1;
          we_d         = 4'hF;
          word_count_d = word_count_q + WordOne;
          // Count saturates at the last index so it never wraps to 0.
          if (count_q == count_max_q) begin
            state_d = StDone;
          end else begin
            count_d = count_q + CountOne;
          end
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  assign busy       = (state_q == StCapture);
  assign done       = (state_q == StDone);
  assign word_count = word_count_q;
  assign bram_addr  = addr_q;
  assign bram_wdata = wdata_q;
  assign bram_en    = en_q;
  assign bram_we    = we_q;

endmodule

// File: tb/tb_bram_capture_writer.sv
module tb_bram_capture_writer;

  localparam int unsigned CW = 4;

  logic          clk;
  logic          resetn;
  logic          start;
  logic          abort;
  logic [CW-1:0] count_max;
  logic [31:0]   s_data;
  logic          s_valid;
  logic          busy;
  logic          done;
  logic [CW:0]   word_count;
  logic [CW+1:0] bram_addr;
  logic [31:0]   bram_wdata;
  logic          bram_en;
  logic [3:0]    bram_we;

  int n_chk;
  int n_fail;

  bram_capture_writer #(
    .COUNT_WIDTH(CW)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .start     (start),
    .abort     (abort),
    .count_max (count_max),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .busy      (busy),
    .done      (done),
    .word_count(word_count),
    .bram_addr (bram_addr),
    .bram_wdata(bram_wdata),
    .bram_en   (bram_en),
    .bram_we   (bram_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          st;
    logic          ab;
    logic [CW-1:0] cm;
    logic          v;
    logic [31:0]   d;
    logic          e_busy;
    logic          e_done;
    logic [CW:0]   e_wc;
    logic [CW+1:0] e_addr;
    logic [31:0]   e_wdata;
    logic          e_en;
    logic [3:0]    e_we;
  } vec_t;

  localparam int NVec = 15;
  vec_t vecs[NVec];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_outs(input string tag, input logic eb, input logic ed,
                            input logic [CW:0] ewc, input logic [CW+1:0] ea,
                            input logic [31:0] ewd, input logic een, input logic [3:0] ewe);
    chk({tag, ".busy"}, 32'(busy), 32'(eb));
    chk({tag, ".done"}, 32'(done), 32'(ed));
    chk({tag, ".word_count"}, 32'(word_count), 32'(ewc));
    chk({tag, ".addr"}, 32'(bram_addr), 32'(ea));
    chk({tag, ".wdata"}, bram_wdata, ewd);
    chk({tag, ".en"}, 32'(bram_en), 32'(een));
    chk({tag, ".we"}, 32'(bram_we), 32'(ewe));
  endtask

  // Drive inputs, let one rising edge pass, then settle before sampling.
  task automatic step(input logic st, input logic ab, input logic [CW-1:0] cm,
                      input logic v, input logic [31:0] d);
    start     = st;
    abort     = ab;
    count_max = cm;
    s_valid   = v;
    s_data    = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;

    // count_max=3, continuous valid; then count_max=2 with gaps, started from DONE.
    vecs[0]  = '{1'b1, 1'b0, 4'd3, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 6'd0,  32'h0,  1'b0, 4'h0};
    vecs[1]  = '{1'b0, 1'b0, 4'd3, 1'b1, 32'hA0, 1'b1, 1'b0, 5'd1, 6'd0,  32'hA0, 1'b1, 4'hF};
    vecs[2]  = '{1'b0, 1'b0, 4'd3, 1'b1, 32'hA1, 1'b1, 1'b0, 5'd2, 6'd4,  32'hA1, 1'b1, 4'hF};
    vecs[3]  = '{1'b0, 1'b0, 4'd3, 1'b1, 32'hA2, 1'b1, 1'b0, 5'd3, 6'd8,  32'hA2, 1'b1, 4'hF};
    vecs[4]  = '{1'b0, 1'b0, 4'd3, 1'b1, 32'hA3, 1'b0, 1'b1, 5'd4, 6'd12, 32'hA3, 1'b1, 4'hF};
    vecs[5]  = '{1'b0, 1'b0, 4'd3, 1'b1, 32'hA4, 1'b0, 1'b1, 5'd4, 6'd12, 32'hA3, 1'b0, 4'h0};
    vecs[6]  = '{1'b1, 1'b0, 4'd2, 1'b0, 32'h0,  1'b1, 1'b0, 5'd0, 6'd12, 32'hA3, 1'b0, 4'h0};
    vecs[7]  = '{1'b0, 1'b0, 4'd2, 1'b1, 32'hB0, 1'b1, 1'b0, 5'd1, 6'd0,  32'hB0, 1'b1, 4'hF};
    vecs[8]  = '{1'b0, 1'b0, 4'd2, 1'b0, 32'h55, 1'b1, 1'b0, 5'd1, 6'd0,  32'hB0, 1'b0, 4'h0};
    vecs[9]  = '{1'b0, 1'b0, 4'd2, 1'b0, 32'h66, 1'b1, 1'b0, 5'd1, 6'd0,  32'hB0, 1'b0, 4'h0};
    vecs[10] = '{1'b0, 1'b0, 4'd2, 1'b1, 32'hB1, 1'b1, 1'b0, 5'd2, 6'd4,  32'hB1, 1'b1, 4'hF};
    vecs[11] = '{1'b0, 1'b0, 4'd2, 1'b0, 32'h77, 1'b1, 1'b0, 5'd2, 6'd4,  32'hB1, 1'b0, 4'h0};
    vecs[12] = '{1'b0, 1'b0, 4'd2, 1'b1, 32'hB2, 1'b0, 1'b1, 5'd3, 6'd8,  32'hB2, 1'b1, 4'hF};
    vecs[13] = '{1'b0, 1'b0, 4'd2, 1'b0, 32'h0,  1'b0, 1'b1, 5'd3, 6'd8,  32'hB2, 1'b0, 4'h0};
    vecs[14] = '{1'b0, 1'b0, 4'd2, 1'b1, 32'hB3, 1'b0, 1'b1, 5'd3, 6'd8,  32'hB2, 1'b0, 4'h0};

    resetn = 1'b0;
    step(1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 4'd0, 1'b0, 32'h0);
    check_outs("reset", 1'b0, 1'b0, 5'd0, 6'd0, 32'h0, 1'b0, 4'h0);
    resetn = 1'b1;

    for (int i = 0; i < NVec; i++) begin
      step(vecs[i].st, vecs[i].ab, vecs[i].cm, vecs[i].v, vecs[i].d);
      check_outs($sformatf("vec%0d", i), vecs[i].e_busy, vecs[i].e_done, vecs[i].e_wc,
                 vecs[i].e_addr, vecs[i].e_wdata, vecs[i].e_en, vecs[i].e_we);
    end

    // Abort after 5 of 10 words; valid on the abort edge must not write.
    step(1'b1, 1'b0, 4'd9, 1'b0, 32'h0);
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0, 4'd9, 1'b1, 32'hC0 + i);
    check_outs("pre_abort", 1'b1, 1'b0, 5'd5, 6'd16, 32'hC4, 1'b1, 4'hF);
    step(1'b0, 1'b1, 4'd9, 1'b1, 32'hC5);
    check_outs("abort", 1'b0, 1'b0, 5'd5, 6'd16, 32'hC4, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'd9, 1'b1, 32'hC6);
    check_outs("post_abort", 1'b0, 1'b0, 5'd5, 6'd16, 32'hC4, 1'b0, 4'h0);
    step(1'b1, 1'b0, 4'd1, 1'b0, 32'h0);
    check_outs("restart", 1'b1, 1'b0, 5'd0, 6'd16, 32'hC4, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'd1, 1'b1, 32'hD0);
    check_outs("restart_w0", 1'b1, 1'b0, 5'd1, 6'd0, 32'hD0, 1'b1, 4'hF);
    step(1'b0, 1'b0, 4'd1, 1'b1, 32'hD1);
    check_outs("restart_w1", 1'b0, 1'b1, 5'd2, 6'd4, 32'hD1, 1'b1, 4'hF);

    // Full depth: 16 words, last address 60, word_count 16, no wrap afterwards.
    step(1'b1, 1'b0, 4'd15, 1'b0, 32'h0);
    check_outs("full_start", 1'b1, 1'b0, 5'd0, 6'd4, 32'hD1, 1'b0, 4'h0);
    for (int i = 0; i < 16; i++) begin
      step(1'b0, 1'b0, 4'd15, 1'b1, 32'hE00 + i);
      check_outs($sformatf("full%0d", i), (i < 15), (i == 15), 5'(i + 1), 6'(i * 4),
                 32'hE00 + i, 1'b1, 4'hF);
    end
    step(1'b0, 1'b0, 4'd15, 1'b1, 32'hEFF);
    check_outs("full_nowrap", 1'b0, 1'b1, 5'd16, 6'd60, 32'hE0F, 1'b0, 4'h0);

    // Abort from DONE, then simultaneous start+abort from IDLE.
    step(1'b0, 1'b1, 4'd3, 1'b0, 32'h0);
    check_outs("done_abort", 1'b0, 1'b0, 5'd16, 6'd60, 32'hE0F, 1'b0, 4'h0);
    step(1'b1, 1'b1, 4'd3, 1'b1, 32'h11);
    check_outs("start_abort", 1'b0, 1'b0, 5'd16, 6'd60, 32'hE0F, 1'b0, 4'h0);
    step(1'b0, 1'b0, 4'd3, 1'b1, 32'h12);
    check_outs("start_abort_idle", 1'b0, 1'b0, 5'd16, 6'd60, 32'hE0F, 1'b0, 4'h0);

    // count_max changed from 7 to 2 after start: still 8 words.
    step(1'b1, 1'b0, 4'd7, 1'b0, 32'h0);
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, 4'd2, 1'b1, 32'hF0 + i);
      check_outs($sformatf("cmchg%0d", i), (i < 7), (i == 7), 5'(i + 1), 6'(i * 4),
                 32'hF0 + i, 1'b1, 4'hF);
    end

    // Reset in the middle of a capture.
    step(1'b1, 1'b0, 4'd5, 1'b0, 32'h0);
    step(1'b0, 1'b0, 4'd5, 1'b1, 32'h21);
    step(1'b0, 1'b0, 4'd5, 1'b1, 32'h22);
    check_outs("pre_reset", 1'b1, 1'b0, 5'd2, 6'd4, 32'h22, 1'b1, 4'hF);
    resetn = 1'b0;
    step(1'b0, 1'b0, 4'd5, 1'b1, 32'h23);
    check_outs("mid_reset", 1'b0, 1'b0, 5'd0, 6'd0, 32'h0, 1'b0, 4'h0);
    resetn = 1'b1;
    step(1'b0, 1'b0, 4'd5, 1'b1, 32'h24);
    check_outs("post_reset", 1'b0, 1'b0, 5'd0, 6'd0, 32'h0, 1'b0, 4'h0);

    // Single-word capture with count_max=0.
    step(1'b1, 1'b0, 4'd0, 1'b0, 32'h0);
    step(1'b0, 1'b0, 4'd0, 1'b1, 32'h31);
    check_outs("single", 1'b0, 1'b1, 5'd1, 6'd0, 32'h31, 1'b1, 4'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bram_capture_writer.md
Name: bram_capture_writer

Overview:
- Writer-side counterpart of the cyclic BRAM address generator.
- On a start pulse, captures count_max+1 consecutive valid 32-bit samples from a stream and writes them into a BRAM port at byte addresses 0, 4, 8, …
- Signals completion to software through busy/done flags and a word counter.
- Sits between an ADC/DSP sample stream and the acquisition BRAM that software later reads over AXI.

Parameters:
- COUNT_WIDTH, 13, width of the word counter; buffer depth is up to 2^COUNT_WIDTH words; the byte address is COUNT_WIDTH+2 bits.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- resetn  input  1  synchronous reset, active-low.
- start  input  1  one-cycle request to begin a capture.
- abort  input  1  one-cycle request to cancel the capture in progress.
- count_max  input  COUNT_WIDTH  index of the last word to capture; latched at start.
- s_data  input  32  sample data.
- s_valid  input  1  s_data is valid this cycle; no backpressure (no ready).
- busy  output  1  capture in progress.
- done  output  1  last capture completed; level, not a pulse.
- word_count  output  COUNT_WIDTH+1  number of words written in the current/last capture.
- bram_addr  output  COUNT_WIDTH+2  BRAM byte address = {count, 2'b00}.
- bram_wdata  output  32  BRAM write data.
- bram_en  output  1  BRAM port enable.
- bram_we  output  4  BRAM byte write enables; all ones or all zeros.

Behaviour:
- Reset (resetn=0 at an edge): state IDLE; busy=0, done=0, word_count=0, bram_addr=0, bram_wdata=0, bram_en=0, bram_we=0. Reset mid-capture discards the capture; done stays 0.
- States: IDLE, CAPTURE, DONE.
- IDLE:
  - start=1 and abort=0 → latch count_max into count_max_reg, clear count and word_count, go to CAPTURE. busy=1 from the next cycle.
- CAPTURE (busy=1, done=0):
  - Each edge with s_valid=1 registers bram_addr={count,2'b00}, bram_wdata=s_data, bram_en=1, bram_we=4'hF.
  - The same edge increments word_count. If count≠count_max_reg, it also increments count.
  - Edge with s_valid=0: bram_en=0, bram_we=0; addr/wdata hold.
  - Write latency is 1 cycle: a sample accepted at edge k is on the BRAM port during cycle k+1.
  - Edge with s_valid=1 and count==count_max_reg: performs the final write and goes to DONE. busy=0 and done=1 on that same edge.
  - abort=1: go to IDLE, with bram_en/bram_we=0 on that edge even if s_valid=1. busy=0; done stays 0; word_count holds the partial count.
  - start during CAPTURE is ignored.
- DONE (done=1):
  - bram_en/bram_we deassert on the next edge.
  - start → behaves as from IDLE, and done clears on that edge.
  - abort → IDLE, done clears.
- Simultaneous start and abort: abort wins; the block ends in IDLE.
- count_max changes after start have no effect until the next start.
- count_max=0 → single-word capture at address 0.
- count_max=2^COUNT_WIDTH−1:
  - Captures 2^COUNT_WIDTH words; the last address is (2^COUNT_WIDTH−1)<<2.
  - word_count reaches 2^COUNT_WIDTH; this is why it is one bit wider than count.
  - count never wraps inside a capture.
- Gaps in s_valid stretch the capture; addresses stay contiguous, with no skipped or duplicated words.

Test Plan:
- count_max=3, start, s_valid held 1 with data 0xA0..0xA3 → writes at addr 0,4,8,12 with data 0xA0..0xA3, we=4'hF for exactly 4 cycles. done=1 and busy=0 on the edge of the 4th write; word_count=4.
- count_max=2, s_valid pattern 1,0,0,1,0,1 → exactly 3 writes at addr 0,4,8. bram_en=0 in gap cycles. done asserts after the 3rd valid.
- Abort after 5 of 10 words → state IDLE, busy=0, done=0, word_count=5, no further writes. A subsequent start restarts at addr 0.
- COUNT_WIDTH=4, count_max=15 → 16 writes, last addr 60, word_count=16, no wrap to addr 0.
- Start and abort in the same cycle from IDLE → no capture, busy stays 0. count_max changed mid-capture from 7 to 2 → capture still writes 8 words.
- resetn=0 mid-capture → on the next edge all outputs are 0 and the state is IDLE. Start from DONE clears done and begins a new capture at addr 0.
